hdmimodelock: RTL
=================

# hdmimodelock

Lock controller for HDMI video-mode measurement. Consumes per-frame horizontal and vertical timing measurements from the mode-measurement blocks and runs a lock state machine. It requires N consecutive identical, sane frames before declaring lock, tolerates brief glitches, and drops lock on persistent mismatch or loss of frame strobes. It publishes a stable, latched mode to the downstream video capture/scaler configuration and a change interrupt to the CPU.

## Interface
- CONFIRM_FRAMES, 4: consecutive matching sane frames needed to lock; legal range 2..15.
- LOSS_FRAMES, 2: consecutive mismatching frames needed to drop lock; legal range 1..15.
- LGTIMEOUT, 24: watchdog width; timeout after 2^LGTIMEOUT-1 cycles with no i_frame_stb.

Ports:
- i_clk  in  1  system/pixel clock; single clock domain.
- i_reset  in  1  asynchronous, active-high reset.
- i_clear  in  1  synchronous restart to SEARCH; no o_int.
- i_frame_stb  in  1  one-cycle strobe; all i_* measurements are valid in this cycle.
- i_npix, i_htotal, i_sstart, i_ssend  in  16 each  horizontal measurement.
- i_nlines, i_vtotal  in  16 each  vertical measurement.
- o_locked  out  1  mode is valid.
- o_npix, o_htotal, o_sstart, o_ssend, o_nlines, o_vtotal  out  16 each  latched mode.
- o_state  out  2  0=SEARCH, 1=CONFIRM, 2=LOCKED, 3=HOLD.
- o_int  out  1  one-cycle pulse on every change of o_locked.

## Operation
- Sane sample: all of the following hold.
  - npix != 0
  - npix < sstart < ssend <= htotal
  - nlines != 0
  - nlines < vtotal
  - All comparisons are unsigned 16-bit. Check is combinational on the i_* inputs.
- Match: all six inputs equal the stored candidate (CONFIRM) or the latched outputs (LOCKED/HOLD).
- State transitions, evaluated only on i_frame_stb:
  - SEARCH
    - sane: capture candidate, cnt=1, go to CONFIRM.
    - otherwise: stay.
  - CONFIRM
    - match: cnt+1. If cnt+1 == CONFIRM_FRAMES: copy candidate to o_*, o_locked=1, o_int, go to LOCKED.
    - sane mismatch: recapture candidate, cnt=1, stay.
    - insane: go to SEARCH.
  - LOCKED
    - match: stay.
    - mismatch (sane or not): miss=1, go to HOLD. If LOSS_FRAMES==1, go directly to SEARCH with o_locked=0 and o_int.
  - HOLD
    - o_locked stays 1; o_* are unchanged.
    - match: miss=0, go to LOCKED.
    - mismatch: miss+1. If miss+1 == LOSS_FRAMES: go to SEARCH, o_locked=0, o_int.
- Watchdog:
  - 16-bit-independent LGTIMEOUT-bit counter.
  - Cleared on i_frame_stb; saturates at all-ones.
  - At all-ones, in any state except SEARCH: go to SEARCH and clear cnt and miss. If o_locked was 1, drop it and pulse o_int.
- o_* mode registers hold their last locked values after lock loss. They are overwritten only at the next lock.
- Counters cnt and miss are 4 bits.

## Timing
- All outputs are registered.
- Reset values: o_locked=0, all o_* mode outputs=0, o_state=0, o_int=0. Internal candidate, cnt, miss and watchdog are also 0.
- Latency: o_locked, o_* and o_int update on the clock edge after the qualifying i_frame_stb, all in the same cycle.
- o_int is high for exactly one cycle per o_locked transition.
- Priorities:
  - i_reset (async) over everything.
  - i_clear over i_frame_stb and the watchdog. i_clear returns to SEARCH, drops o_locked with no o_int, and keeps the o_* values.
  - i_frame_stb over watchdog expiry in the same cycle: the strobe is processed and the counter clears.
- Back-to-back strobes on consecutive cycles are legal; each is evaluated.
- Reset asserted mid-CONFIRM or mid-HOLD: outputs go to reset values immediately and asynchronously.

## Structure
- Shared package (hdmi_pkg) holds the state encodings SEARCH/CONFIRM/LOCKED/HOLD.
- It also holds a 96-bit packed mode bundle (npix, htotal, sstart, ssend, nlines, vtotal), used for the candidate, compare and latch.
- One natural sub-module: hdmimodesane. It is combinational, takes the mode bundle and outputs the sane flag, and is reusable by software-visible status logic.
- The watchdog is inline.

## Test plan
- Lock: 4 strobes of the sane 1080p mode (npix=1920, sstart=2008, ssend=2052, htotal=2200, nlines=1080, vtotal=1125). Required response:
  - o_locked=1 and o_int pulses one cycle after the 4th strobe.
  - o_* equal the inputs.
  - o_state is 1 after strobes 1–3.
- Glitch tolerance: locked, then 1 frame with htotal=2199, then a correct frame. Required response:
  - HOLD (o_state=3) then LOCKED.
  - o_locked stays 1 throughout, with no o_int.
- Loss: locked, then 2 mismatching frames. Required response:
  - o_locked=0 and o_int after the 2nd.
  - o_* still hold the 1080p values.
- Insane/recapture: strobe with sstart=1900 (< npix) stays in SEARCH. In CONFIRM with cnt=3, a sane 720p frame resets cnt to 1; 3 more 720p frames then lock 720p.
- Watchdog with LGTIMEOUT=8: locked, then no strobe for 255 cycles. Required response: o_locked=0, o_int, o_state=0. Also check that a strobe on the expiry cycle keeps lock.
- Clear/reset: i_clear asserted together with a strobe while locked gives SEARCH, o_locked=0, no o_int. Asserting i_reset mid-CONFIRM zeroes all outputs asynchronously.

Source files
------------

// File: rtl/hdmi_pkg.sv
// Shared types for the HDMI mode-lock controller: lock states and the
// 96-bit measured-mode bundle used for candidate, compare and latch.
package hdmi_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  typedef struct packed {
    logic [15:0] npix;
    logic [15:0] htotal;
    logic [15:0] sstart;
    logic [15:0] ssend;
    logic [15:0] nlines;
    logic [15:0] vtotal;
  } mode_t;

  localparam int MODE_W = $bits(mode_t);

endpackage

// File: rtl/hdmimodesane.sv
// Combinational plausibility check of one measured video mode.
module hdmimodesane
  import hdmi_pkg::*;
(
  input  mode_t mode,
  output logic  sane
);

  // Horizontal: active < sync start < sync end <= total; vertical: active < total.
  assign sane = (mode.npix != 16'd0)
             && (mode.npix < mode.sstart)
             && (mode.sstart < mode.ssend)
             && (mode.ssend <= mode.htotal)
             && (mode.nlines != 16'd0)
             && (mode.nlines < mode.vtotal);

endmodule

// File: rtl/hdmimodelock.sv
// Lock controller: confirms a stable, sane mode over several frames, tolerates
// short glitches, and publishes the latched mode plus a lock-change interrupt.
module hdmimodelock
  import hdmi_pkg::*;
#(
  parameter int CONFIRM_FRAMES = 4,
  parameter int LOSS_FRAMES    = 2,
  parameter int LGTIMEOUT      = 24
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_frame_stb,
  input  logic [15:0] i_npix,
  input  logic [15:0] i_htotal,
  input  logic [15:0] i_sstart,
  input  logic [15:0] i_ssend,
  input  logic [15:0] i_nlines,
  input  logic [15:0] i_vtotal,
  output logic        o_locked,
  output logic [15:0] o_npix,
  output logic [15:0] o_htotal,
  output logic [15:0] o_sstart,
  output logic [15:0] o_ssend,
  output logic [15:0] o_nlines,
  output logic [15:0] o_vtotal,
  output logic [1:0]  o_state,
  output logic        o_int
);

  localparam logic [3:0] CONFIRM_N = 4'(CONFIRM_FRAMES);
  localparam logic [3:0] LOSS_N    = 4'(LOSS_FRAMES);

  state_t               state, state_nx;
  mode_t                meas, cand, cand_nx, latched, latched_nx;
  logic [3:0]           cnt, cnt_nx, miss, miss_nx;
  logic [LGTIMEOUT-1:0] wd, wd_nx;
  logic                 locked_nx, int_nx;
  logic                 sane, match_cand, match_lock, wd_expired;
  logic [3:0]           cnt_inc, miss_inc;

  assign meas = '{npix: i_npix, htotal: i_htotal, sstart: i_sstart,
                  ssend: i_ssend, nlines: i_nlines, vtotal: i_vtotal};

  hdmimodesane u_sane (
    .mode (meas),
    .sane (sane)
  );

  assign match_cand = (meas == cand);
  assign match_lock = (meas == latched);
  assign wd_expired = &wd;
  assign cnt_inc    = cnt + 4'd1;
  assign miss_inc   = miss + 4'd1;

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path infers a latch;
    // combinational logic uses blocking '=', the register process uses '<='.
    state_nx   = state;
    cand_nx    = cand;
    latched_nx = latched;
    cnt_nx     = cnt;
    miss_nx    = miss;
    locked_nx  = o_locked;
    int_nx     = 1'b0;
    wd_nx      = wd;

    if (i_clear) begin
      // Software restart: silent unlock, latched mode kept for inspection.
      state_nx  = ST_SEARCH;
      cnt_nx    = '0;
      miss_nx   = '0;
      locked_nx = 1'b0;
      wd_nx     = '0;
    end else if (i_frame_stb) begin
      wd_nx = '0;
      unique case (state)
        ST_SEARCH: begin
          if (sane) begin
            cand_nx  = meas;
            cnt_nx   = 4'd1;
            state_nx = ST_CONFIRM;
          end
        end
        ST_CONFIRM: begin
          if (match_cand) begin
            if (cnt_inc == CONFIRM_N) begin
              latched_nx = cand;
              locked_nx  = 1'b1;
              int_nx     = 1'b1;
              miss_nx    = '0;
              state_nx   = ST_LOCKED;
            end else begin
              cnt_nx = cnt_inc;
            end
          end else if (sane) begin
            cand_nx = meas;
            cnt_nx  = 4'd1;
          end else begin
            cnt_nx   = '0;
            state_nx = ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          if (!match_lock) begin
            if (LOSS_N == 4'd1) begin
              locked_nx = 1'b0;
              int_nx    = 1'b1;
              cnt_nx    = '0;
              miss_nx   = '0;
              state_nx  = ST_SEARCH;
            end else begin
              miss_nx  = 4'd1;
              state_nx = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (match_lock) begin
            miss_nx  = '0;
            state_nx = ST_LOCKED;
          end else if (miss_inc == LOSS_N) begin
            locked_nx = 1'b0;
            int_nx    = 1'b1;
            cnt_nx    = '0;
            miss_nx   = '0;
            state_nx  = ST_SEARCH;
          end else begin
            miss_nx = miss_inc;
          end
        end
        default: state_nx = ST_SEARCH;
      endcase
    end else if (wd_expired) begin
      // Strobes have stopped: abandon any lock attempt; counter stays saturated.
      if (state != ST_SEARCH) begin
        state_nx = ST_SEARCH;
        cnt_nx   = '0;
        miss_nx  = '0;
        if (o_locked) begin
          locked_nx = 1'b0;
          int_nx    = 1'b1;
        end
      end
    end else begin
      wd_nx = wd + 1'b1;
    end
  end

  // NOTE: candidate and latched mode are plain registers, so all of them are reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= ST_SEARCH;
      cand     <= '0;
      latched  <= '0;
      cnt      <= '0;
      miss     <= '0;
      o_locked <= 1'b0;
      o_int    <= 1'b0;
      wd       <= '0;
    end else begin
      state    <= state_nx;
      cand     <= cand_nx;
      latched  <= latched_nx;
      cnt      <= cnt_nx;
      miss     <= miss_nx;
      o_locked <= locked_nx;
      o_int    <= int_nx;
      wd       <= wd_nx;
    end
  end

  assign o_state  = state;
  assign o_npix   = latched.npix;
  assign o_htotal = latched.htotal;
  assign o_sstart = latched.sstart;
  assign o_ssend  = latched.ssend;
  assign o_nlines = latched.nlines;
  assign o_vtotal = latched.vtotal;

endmodule
